// File: rtl/jk_pkg.sv
// Shared JK excitation encodings and helper for the JK-based counters.
// Exports JK_* {J,K} codes and jk_excite(q, nxt) -> {J,K}.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Only set/clear/hold are ever produced; toggle is never needed.
    function automatic logic [1:0] jk_excite(input logic q,
                                             input logic nxt);
        return {~q & nxt, q & ~nxt};
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop with synchronous active-low reset (q=0).
// Ports: clk, reset, j, k in; q, qb out.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                JK_HOLD: q <= q;
                JK_RST:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TOG:  q <= ~q;
            endcase
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from JK cells, with load, tc, wrap, lerr.
// Ports: clk, reset, en, up, load, d in; q, qb, tc, wrap, lerr out.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             wrap,
    output logic             lerr
);

    // Range compares use one extra bit so MODULUS = 2**WIDTH fits.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO  = '0;

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j_w;
    logic [WIDTH-1:0] k_w;
    logic             wrap_d;
    logic             lerr_d;
    logic             wrap_q;
    logic             lerr_q;
    logic             d_ok;
    logic             q_oor;

    assign d_ok  = ({1'b0, d} < MOD_W);
    assign q_oor = ({1'b0, q} >= MOD_W);

    always_comb begin
        nxt    = q;
        wrap_d = 1'b0;
        lerr_d = 1'b0;
        if (load) begin
            if (d_ok) begin
                nxt = d;
            end else begin
                nxt    = ZERO;
                lerr_d = 1'b1;
            end
        end else if (en) begin
            if (q_oor) begin
                // Recover from a forced illegal state.
                nxt = ZERO;
            end else if (up) begin
                if (q == MAX) begin
                    nxt    = ZERO;
                    wrap_d = 1'b1;
                end else begin
                    nxt = q + WIDTH'(1);
                end
            end else begin
                if (q == ZERO) begin
                    nxt    = MAX;
                    wrap_d = 1'b1;
                end else begin
                    nxt = q - WIDTH'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign {j_w[i], k_w[i]} = jk_excite(q[i], nxt[i]);

        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j_w[i]),
            .k     (k_w[i]),
            .q     (q[i]),
            .qb    (qb[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            lerr_q <= lerr_d;
        end
    end

    // Combinational so a cascaded stage sees it in the same cycle.
    assign tc   = en & ((up & (q == MAX)) | (~up & (q == ZERO)));
    assign wrap = wrap_q;
    assign lerr = lerr_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed self-checking bench for jk_mod_counter.
// Single instance plus a two-digit BCD cascade.
module tb_jk_mod_counter;

    logic       clk = 1'b0;
    logic       reset, en, up, load;
    logic [3:0] d;
    logic [3:0] q, qb;
    logic       tc, wrap, lerr;

    logic       c_reset;
    logic [3:0] q0, qb0, q1, qb1;
    logic       tc0, tc1, wrap0, wrap1, lerr0, lerr1;

    int checks = 0;
    int errors = 0;
    bit jk_mon = 1'b0;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
        .q(q), .qb(qb), .tc(tc), .wrap(wrap), .lerr(lerr)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u0 (
        .clk(clk), .reset(c_reset), .en(1'b1), .up(1'b1), .load(1'b0),
        .d(4'd0), .q(q0), .qb(qb0), .tc(tc0), .wrap(wrap0), .lerr(lerr0)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u1 (
        .clk(clk), .reset(c_reset), .en(tc0), .up(1'b1), .load(1'b0),
        .d(4'd0), .q(q1), .qb(qb1), .tc(tc1), .wrap(wrap1), .lerr(lerr1)
    );

    always @(negedge clk) begin
        if (jk_mon) begin
            checks++;
            if (((dut.j_w & dut.k_w) | (u0.j_w & u0.k_w)
                 | (u1.j_w & u1.k_w)) !== 4'b0) begin
                errors++;
                $display("FAIL jk_both_high: dut j=%b k=%b u0 j=%b k=%b u1 j=%b k=%b",
                         dut.j_w, dut.k_w, u0.j_w, u0.k_w, u1.j_w, u1.k_w);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; d = 4'd5;
        c_reset = 1'b0;
        tick();
        tick();
        checks++;
        if (q !== 4'd0 || qb !== 4'hF || wrap !== 1'b0 || lerr !== 1'b0) begin
            errors++;
            $display("FAIL reset: q=%h qb=%h wrap=%b lerr=%b want 0 F 0 0",
                     q, qb, wrap, lerr);
        end
        jk_mon = 1'b1;
    endtask

    task automatic test_count_up();
        int e;
        reset = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            e = (i + 1) % 10;
            checks++;
            if (q !== 4'(e) || qb !== ~4'(e) || wrap !== (e == 0)
                || tc !== (e == 9)) begin
                errors++;
                $display("FAIL count_up[%0d]: q=%0d wrap=%b tc=%b want %0d %b %b",
                         i, q, wrap, tc, e, (e == 0), (e == 9));
            end
        end
    endtask

    task automatic test_count_down();
        int exp_q [5] = '{2, 1, 0, 9, 8};
        load = 1'b1; d = 4'd3;
        tick();
        load = 1'b0; up = 1'b0; en = 1'b1;
        #1;
        checks++;
        if (q !== 4'd3 || wrap !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL load3: q=%0d wrap=%b tc=%b want 3 0 0", q, wrap, tc);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (q !== 4'(exp_q[i]) || wrap !== (exp_q[i] == 9)
                || tc !== (exp_q[i] == 0)) begin
                errors++;
                $display("FAIL count_down[%0d]: q=%0d wrap=%b tc=%b want %0d %b %b",
                         i, q, wrap, tc, exp_q[i], (exp_q[i] == 9), (exp_q[i] == 0));
            end
        end
    endtask

    task automatic test_load_err();
        en = 1'b0; load = 1'b1; d = 4'd12;
        tick();
        checks++;
        if (q !== 4'd0 || lerr !== 1'b1 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_oor: q=%0d lerr=%b wrap=%b want 0 1 0", q, lerr, wrap);
        end
        d = 4'd7;
        tick();
        checks++;
        if (q !== 4'd7 || lerr !== 1'b0) begin
            errors++;
            $display("FAIL load7: q=%0d lerr=%b want 7 0", q, lerr);
        end
        d = 4'd15;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (q !== 4'd0 || lerr !== 1'b0) begin
            errors++;
            $display("FAIL lerr_pulse: q=%0d lerr=%b want 0 0", q, lerr);
        end
    endtask

    task automatic test_load_priority();
        en = 1'b0; load = 1'b1; d = 4'd9;
        tick();
        en = 1'b1; up = 1'b1; d = 4'd4;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL tc_ungated: tc=%b want 1", tc);
        end
        tick();
        checks++;
        if (q !== 4'd4 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_beats_count: q=%0d wrap=%b want 4 0", q, wrap);
        end
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q !== 4'd4 || tc !== 1'b0 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: q=%0d tc=%b wrap=%b want 4 0 0",
                         i, q, tc, wrap);
            end
        end
    endtask

    task automatic test_dir_change();
        en = 1'b1; up = 1'b1;
        tick();
        up = 1'b0;
        tick();
        checks++;
        if (q !== 4'd4) begin
            errors++;
            $display("FAIL dir_change: q=%0d want 4", q);
        end
        reset = 1'b0; load = 1'b1; d = 4'd6;
        tick();
        reset = 1'b1; load = 1'b0; en = 1'b0;
        checks++;
        if (q !== 4'd0 || wrap !== 1'b0 || lerr !== 1'b0) begin
            errors++;
            $display("FAIL reset_vs_load: q=%0d want 0", q);
        end
    endtask

    task automatic test_cascade();
        int n;
        c_reset = 1'b0;
        tick();
        c_reset = 1'b1;
        for (int i = 1; i <= 157; i++) begin
            tick();
            n = i % 100;
            checks++;
            if (q1 !== 4'(n / 10) || q0 !== 4'(n % 10)) begin
                errors++;
                $display("FAIL cascade[%0d]: got %0d%0d want %0d%0d",
                         i, q1, q0, n / 10, n % 10);
            end
        end
        c_reset = 1'b0;
        tick();
        checks++;
        if (q1 !== 4'd0 || q0 !== 4'd0) begin
            errors++;
            $display("FAIL cascade_reset: got %0d%0d want 00", q1, q0);
        end
        c_reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load_err();
        test_load_priority();
        test_dir_change();
        test_cascade();
        tick();
        jk_mon = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
